axi4_lite_mgr: RTL
==================

# axi4_lite_mgr

AXI4-Lite manager that converts a simple single-beat command/response interface into AXI4-Lite read and write transactions. It sits between internal control logic (CPU bridge, test sequencer, config engine) and any AXI4-Lite subordinate register bank in the design, with one transaction outstanding at a time. Results are returned on a registered response channel with held-until-accepted semantics.

## Interface
- DATA_WIDTH, 32, width of wdata/rdata and cmd/rsp data
- ADDR_WIDTH, 32, width of awaddr/araddr and cmd_addr
- TIMEOUT_CYCLES, 256, watchdog limit in aclk cycles (used only with timeout feature)

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target byte address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  captured bresp/rresp, or 2'b10 on timeout
- rsp_timeout  out  1  1 = transaction aborted by watchdog
- m_axi  axi4_if.manager  drives awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready; samples awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1 (only state where it is 1). On accept, latch addr/wdata/write; go WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid both asserted; each drops independently on its own handshake (awvalid&&awready, wvalid&&wready). When both done (same or different cycles) go WR_RESP.
- WR_RESP: bready=1; on bvalid capture bresp, rsp_rdata=0, go RSP.
- RD_REQ: arvalid=1 until arready; then go RD_DATA.
- RD_DATA: rready=1; on rvalid capture rdata/rresp, drop rready, go RSP.
- RSP: rsp_valid=1, data/resp held stable; on rsp_ready go IDLE.
- Valid signals never depend on the corresponding ready; once asserted, held with stable addr/data until handshake.
- All AXI and rsp outputs are registered.

## Timing
- Reset values: cmd_ready=0 during reset, 1 the first cycle after release; awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout=0; addr/data/resp outputs=0.
- Accept at edge N -> awvalid/wvalid (or arvalid) high from N+1.
- Minimum write latency (ready already high, bvalid in first bready cycle): accept N, AW/W handshake N+1, B handshake N+2, rsp_valid N+3.
- Minimum read latency: accept N, AR N+1, R N+2, rsp_valid N+3.
- Back-to-back: next cmd accepted the cycle after rsp handshake (IDLE visited one cycle).
- bvalid/rvalid arriving before bready/rready asserted is held by the subordinate and consumed on entry to WR_RESP/RD_DATA.
- Reset asserted mid-transaction: immediate return to IDLE, all valids/readies low, no response issued.

## Configuration
- AXI4_LITE_MGR_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WR_REQ/RD_REQ, increments each cycle in WR_REQ, WR_RESP, RD_REQ, RD_DATA. On reaching TIMEOUT_CYCLES: drop all AXI valids/readies, go RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
- Not defined: no counter; FSM waits indefinitely; rsp_timeout tied 0.

## Test plan
- Write addr 0x04 data 0xDEADBEEF, subordinate ready immediately, bresp=00 -> rsp_valid at accept+3, rsp_resp=00, rsp_rdata=0.
- Read addr 0x04 after that write -> rsp_rdata=0xDEADBEEF, rsp_resp=00, arvalid held until arready delayed 3 cycles.
- awready 2 cycles before wready -> awvalid drops after its handshake, wvalid stays high until its own; exactly one B response consumed.
- rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; next cmd accepted 1 cycle after rsp handshake.
- aresetn low during WR_RESP -> all valids 0 asynchronously, no rsp_valid; new read after release completes normally.
- With AXI4_LITE_MGR_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never asserted -> arvalid drops, rsp_resp=2'b10, rsp_timeout=1 at cycle 16.

Source files
------------

// File: rtl/axi4_lite_mgr.sv
// ---------------------------------------------------------------------------
// axi4_lite_mgr
//
// Turns a simple single-beat command/response handshake into AXI4-Lite read
// and write transactions. Only one transaction is outstanding at a time. The
// result is returned on a registered response channel and held until the
// requester accepts it.
//
// Optional feature macro: AXI4_LITE_MGR_TIMEOUT_EN
//   When defined, a watchdog aborts any transaction that has not completed
//   within TIMEOUT_CYCLES aclk cycles. The aborted transaction returns
//   rsp_resp = 2'b10 (SLVERR) with rsp_timeout = 1. When the macro is not
//   defined, the manager waits indefinitely and o_rsp_timeout is tied low.
//
// Ports
//   aclk, aresetn            clock (rising edge), async active-low reset
//   i_cmd_valid/o_cmd_ready  command handshake
//   i_cmd_write              1 = write, 0 = read
//   i_cmd_addr, i_cmd_wdata  target byte address and write data
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_rdata              read data (0 for writes and timeouts)
//   o_rsp_resp               captured BRESP/RRESP, or 2'b10 on timeout
//   o_rsp_timeout            transaction aborted by the watchdog
//   o_m_axi_* / i_m_axi_*    AXI4-Lite manager channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi4_lite_mgr #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,

    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_rsp_timeout,

    output logic [ADDR_WIDTH-1:0] o_m_axi_awaddr,
    output logic                  o_m_axi_awvalid,
    input  logic                  i_m_axi_awready,
    output logic [DATA_WIDTH-1:0] o_m_axi_wdata,
    output logic                  o_m_axi_wvalid,
    input  logic                  i_m_axi_wready,
    input  logic                  i_m_axi_bvalid,
    input  logic [1:0]            i_m_axi_bresp,
    output logic                  o_m_axi_bready,
    output logic [ADDR_WIDTH-1:0] o_m_axi_araddr,
    output logic                  o_m_axi_arvalid,
    input  logic                  i_m_axi_arready,
    input  logic                  i_m_axi_rvalid,
    input  logic [DATA_WIDTH-1:0] i_m_axi_rdata,
    input  logic [1:0]            i_m_axi_rresp,
    output logic                  o_m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_cmd_ready,  w_cmd_ready;
    logic                  r_awvalid,    w_awvalid;
    logic                  r_wvalid,     w_wvalid;
    logic                  r_bready,     w_bready;
    logic                  r_arvalid,    w_arvalid;
    logic                  r_rready,     w_rready;
    logic                  r_rsp_valid,  w_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_addr,       w_addr;
    logic [DATA_WIDTH-1:0] r_wdata,      w_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata;
    logic [1:0]            r_rsp_resp,   w_rsp_resp;

`ifdef AXI4_LITE_MGR_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0]    r_timer;
    logic                  r_rsp_timeout, w_rsp_timeout;
    logic                  w_busy;
`endif

    // Next-state and next-output logic. Every output is a register, so this
    // block computes the value each output register takes at the next edge;
    // everything holds by default.
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = r_cmd_ready;
        w_awvalid    = r_awvalid;
        w_wvalid     = r_wvalid;
        w_bready     = r_bready;
        w_arvalid    = r_arvalid;
        w_rready     = r_rready;
        w_rsp_valid  = r_rsp_valid;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_rsp_rdata  = r_rsp_rdata;
        w_rsp_resp   = r_rsp_resp;
`ifdef AXI4_LITE_MGR_TIMEOUT_EN
        w_rsp_timeout = r_rsp_timeout;
        w_busy        = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                // cmd_ready comes up on the first edge in IDLE, which also
                // covers the first cycle after reset release.
                w_cmd_ready = 1'b1;
                if (i_cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    w_addr      = i_cmd_addr;
                    w_wdata     = i_cmd_wdata;
                    if (i_cmd_write) begin
                        w_awvalid    = 1'b1;
                        w_wvalid     = 1'b1;
                        w_next_state = WR_REQ;
                    end else begin
                        w_arvalid    = 1'b1;
                        w_next_state = RD_REQ;
                    end
                end
            end

            WR_REQ: begin
                // AW and W complete independently; leave once both are done,
                // whether that happened in the same cycle or not.
                if (r_awvalid && i_m_axi_awready) begin
                    w_awvalid = 1'b0;
                end
                if (r_wvalid && i_m_axi_wready) begin
                    w_wvalid = 1'b0;
                end
                if (!w_awvalid && !w_wvalid) begin
                    w_bready     = 1'b1;
                    w_next_state = WR_RESP;
                end
            end

            WR_RESP: begin
                if (i_m_axi_bvalid) begin
                    w_bready     = 1'b0;
                    w_rsp_rdata  = '0;
                    w_rsp_resp   = i_m_axi_bresp;
                    w_rsp_valid  = 1'b1;
                    w_next_state = RSP;
                end
            end

            RD_REQ: begin
                if (i_m_axi_arready) begin
                    w_arvalid    = 1'b0;
                    w_rready     = 1'b1;
                    w_next_state = RD_DATA;
                end
            end

            RD_DATA: begin
                if (i_m_axi_rvalid) begin
                    w_rready     = 1'b0;
                    w_rsp_rdata  = i_m_axi_rdata;
                    w_rsp_resp   = i_m_axi_rresp;
                    w_rsp_valid  = 1'b1;
                    w_next_state = RSP;
                end
            end

            RSP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid  = 1'b0;
                    w_cmd_ready  = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase

`ifdef AXI4_LITE_MGR_TIMEOUT_EN
        // The watchdog overrides whatever the channel logic decided above:
        // on the last allowed cycle every valid/ready is dropped and a
        // SLVERR response is produced instead.
        w_busy = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                 (r_state == RD_REQ) || (r_state == RD_DATA);
        if (r_state == RSP && i_rsp_ready) begin
            w_rsp_timeout = 1'b0;
        end
        if (w_busy && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1))) begin
            w_awvalid     = 1'b0;
            w_wvalid      = 1'b0;
            w_bready      = 1'b0;
            w_arvalid     = 1'b0;
            w_rready      = 1'b0;
            w_rsp_rdata   = '0;
            w_rsp_resp    = 2'b10;
            w_rsp_timeout = 1'b1;
            w_rsp_valid   = 1'b1;
            w_next_state  = RSP;
        end
`endif
    end

    // State and output registers. Reset drops every valid/ready at once and
    // discards any transaction in flight without producing a response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= w_cmd_ready;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_rsp_valid <= w_rsp_valid;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_resp  <= w_rsp_resp;
        end
    end

`ifdef AXI4_LITE_MGR_TIMEOUT_EN
    // Watchdog counter: zero whenever idle or responding, so it is already
    // clear on entry to WR_REQ/RD_REQ, and counts every cycle spent waiting
    // on the subordinate.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_timer       <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_timeout <= w_rsp_timeout;
            if (w_busy) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign o_rsp_timeout = r_rsp_timeout;
`else
    assign o_rsp_timeout = 1'b0;
`endif

    assign o_cmd_ready     = r_cmd_ready;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_rsp_resp      = r_rsp_resp;
    assign o_m_axi_awaddr  = r_addr;
    assign o_m_axi_awvalid = r_awvalid;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wvalid  = r_wvalid;
    assign o_m_axi_bready  = r_bready;
    assign o_m_axi_araddr  = r_addr;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_rready  = r_rready;

endmodule
